// File: rtl/sreg_ctrl.sv
// sreg_ctrl: handshake-driven controller that loads a word into a 4-bit shift register and shifts/rotates it 4 times.
// Optional macro SREG_CTRL_BACKTOBACK_EN lets a new word be accepted in FIN.
module sreg_ctrl (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [3:0] IN_DATA,
    input  logic       IN_DIR,
    input  logic       IN_ROT,
    input  logic       IN_FILL,
    output logic       ENB,
    output logic [1:0] MODE,
    output logic       DIR,
    output logic       S_IN,
    output logic [3:0] D,
    output logic       BUSY,
    output logic       DONE
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] data_q;
    logic       dir_q, rot_q, fill_q, run_q, hs;
    assign hs = IN_VALID && IN_READY;
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            data_q  <= 4'd0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (hs) begin
                data_q <= IN_DATA;
                dir_q  <= IN_DIR;
                rot_q  <= IN_ROT;
                fill_q <= IN_FILL;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = hs ? LOAD : IDLE;
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = 2'd0;
            end
            SHIFT: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == 2'd3) ? FIN : SHIFT;
            end
            FIN:   state_d = hs ? LOAD : IDLE;
        endcase
    end
    // run_q delays IN_READY until the first edge that samples RESET_L high
    always_comb begin
`ifdef SREG_CTRL_BACKTOBACK_EN
        IN_READY = RESET_L && run_q && (state_q == IDLE || state_q == FIN);
`else
        IN_READY = RESET_L && run_q && (state_q == IDLE);
`endif
        ENB  = (state_q == LOAD) || (state_q == SHIFT);
        MODE = (state_q == LOAD) ? 2'b10 : (state_q == SHIFT) ? {1'b0, rot_q} : 2'b00;
        DIR  = (state_q == SHIFT) && dir_q;
        S_IN = (state_q == SHIFT) && fill_q;
        D    = (state_q == LOAD) ? data_q : 4'd0;
        BUSY = state_q != IDLE;
        DONE = state_q == FIN;
    end
endmodule

// File: tb/tb_sreg_ctrl.sv
// tb_sreg_ctrl: directed bench with a word-timeline model of sreg_ctrl and an attached 4-bit shift register.
module tb_sreg_ctrl;
    logic       CLK = 1'b0, RESET_L = 1'b0, IN_VALID = 1'b0, IN_DIR = 1'b0, IN_ROT = 1'b0, IN_FILL = 1'b0;
    logic [3:0] IN_DATA = 4'd0;
    logic       IN_READY, ENB, DIR, S_IN, BUSY, DONE;
    logic [1:0] MODE;
    logic [3:0] D;
    logic [3:0] q = 4'd0;
    int checks = 0, failures = 0, cyc = 0;
`ifdef SREG_CTRL_BACKTOBACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    sreg_ctrl dut (
        .CLK(CLK), .RESET_L(RESET_L), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_DIR(IN_DIR), .IN_ROT(IN_ROT), .IN_FILL(IN_FILL),
        .ENB(ENB), .MODE(MODE), .DIR(DIR), .S_IN(S_IN), .D(D), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Downstream shift register driven by the DUT outputs
    always @(posedge CLK)
        if (ENB)
            case (MODE)
                2'b10:   q <= D;
                2'b01:   q <= DIR ? {q[0], q[3:1]} : {q[2:0], q[3]};
                default: q <= DIR ? {S_IN, q[3:1]} : {q[2:0], S_IN};
            endcase

    // Model: age = cycles since the accepting edge (-1 when no word): 0 load, 1..4 shift, 5 done
    int         age = -1;
    logic       prev_rst = 1'b0;
    logic [3:0] m_data = 4'd0;
    logic       m_dir = 1'b0, m_rot = 1'b0, m_fill = 1'b0;

    function automatic logic m_ready();
        return RESET_L && prev_rst && (age == -1 || (B2B && age == 5));
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (!RESET_L) begin
            age = -1;
            {m_data, m_dir, m_rot, m_fill} = 7'd0;
        end else if (IN_VALID && m_ready()) begin
            age = 0;
            {m_data, m_dir, m_rot, m_fill} = {IN_DATA, IN_DIR, IN_ROT, IN_FILL};
        end else if (age >= 0)
            age = (age == 5) ? -1 : age + 1;
        prev_rst = RESET_L;
    end

    always @(negedge CLK)
        if (cyc > 0) begin
            logic sh;
            logic [11:0] exp;
            sh  = age >= 1 && age <= 4;
            exp = {m_ready(), age >= 0 && age <= 4,
                   age == 0 ? 2'b10 : sh ? {1'b0, m_rot} : 2'b00,
                   sh && m_dir, sh && m_fill, age == 0 ? m_data : 4'd0,
                   age >= 0, age == 5};
            chk("outputs", {IN_READY, ENB, MODE, DIR, S_IN, D, BUSY, DONE}, exp);
        end

    task automatic word(input logic [3:0] d, input logic dr, rt, fl,
                        input logic [3:0] e0, e1, e2, e3, e4);
        logic [3:0] e[5];
        int n;
        e = '{e0, e1, e2, e3, e4};
        @(posedge CLK); #1;
        {IN_DATA, IN_DIR, IN_ROT, IN_FILL} = {d, dr, rt, fl};
        IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("ready_wait", {11'd0, n < 20}, 12'd1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        IN_DATA  = ~d;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            chk($sformatf("q[%0d]", i), {8'd0, q}, {8'd0, e[i]});
        end
        chk("done_pulse", {11'd0, DONE}, 12'd1);
        @(negedge CLK);
        chk("done_clear", {11'd0, DONE}, 12'd0);
    endtask

    initial begin
        int hs[$];
        int n;
        logic saw_done;
        repeat (3) @(posedge CLK);
        #1 RESET_L = 1'b1;
        @(negedge CLK);
        chk("ready_before_sample", {11'd0, IN_READY}, 12'd0);
        @(negedge CLK);
        chk("ready_after_release", {10'd0, IN_READY, ENB}, 12'b10);

        word(4'b0111, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000);
        word(4'b1000, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000);
        word(4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b1000, 4'b1100, 4'b1110, 4'b1111);
        word(4'b1011, 1'b1, 1'b1, 1'b0, 4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b1011);

        // Abort during the second shift cycle
        @(posedge CLK); #1;
        {IN_DATA, IN_DIR, IN_ROT, IN_FILL, IN_VALID} = {4'b1010, 1'b0, 1'b0, 1'b1, 1'b1};
        n = 0;
        while (!IN_READY && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        repeat (3) @(posedge CLK);
        #1 IN_VALID = 1'b0;
        RESET_L = 1'b0;
        @(posedge CLK); #1;
        chk("abort_idle", {10'd0, ENB, BUSY}, 12'd0);
        RESET_L = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            saw_done |= DONE;
        end
        chk("abort_no_done", {11'd0, saw_done}, 12'd0);
        chk("abort_ready", {11'd0, IN_READY}, 12'd1);

        // IN_VALID held high: three words, data scrambled every cycle
        IN_VALID = 1'b1;
        n = 0;
        while (hs.size() < 3 && n < 40) begin
            @(negedge CLK);
            if (IN_VALID && IN_READY) hs.push_back(cyc);
            @(posedge CLK); #1;
            {IN_DATA, IN_DIR, IN_ROT, IN_FILL} = 7'($urandom);
            n++;
        end
        IN_VALID = 1'b0;
        chk("b2b_count", 12'(hs.size()), 12'd3);
        if (hs.size() == 3) begin
            chk("b2b_gap1", 12'(hs[1] - hs[0]), B2B ? 12'd6 : 12'd7);
            chk("b2b_gap2", 12'(hs[2] - hs[1]), B2B ? 12'd6 : 12'd7);
        end
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
